microcode_sequencer: RTL

Sequences the microcode store. Drives the read port of an external sram_1r1w (DATA_WIDTH x SIZE, 1-cycle read latency) to issue one micro-op per cycle, with jump, call and return branching through a return stack. Owns the write port so a host can load microcode while the sequencer is halted. Sits between the host/control interface and the datapath that consumes ctrl_out.

---
 rtl/microcode_sequencer_if.sv | 38 +++
 rtl/microcode_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/microcode_sequencer_if.sv
// Host, datapath and microcode-SRAM signals of the microcode sequencer.
// slave is the sequencer's view; master is the surrounding environment.
interface microcode_sequencer_if #(
    parameter int DATA_WIDTH = 46,
    parameter int ADDR_WIDTH = 10,
    parameter int CTRL_WIDTH = DATA_WIDTH - 4 - ADDR_WIDTH
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  stall;
    logic                  cond;
    logic                  uop_valid;
    logic [CTRL_WIDTH-1:0] ctrl_out;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  running;
    logic                  error;
    logic                  load_valid;
    logic                  load_ready;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;
    logic [ADDR_WIDTH-1:0] sram_rd_addr;
    logic [DATA_WIDTH-1:0] sram_rd_data;
    logic                  sram_wr_enable;
    logic [ADDR_WIDTH-1:0] sram_wr_addr;
    logic [DATA_WIDTH-1:0] sram_wr_data;

    modport slave (
        input  start, start_addr, stall, cond, load_valid, load_addr, load_data, sram_rd_data,
        output uop_valid, ctrl_out, pc, running, error, load_ready,
               sram_rd_addr, sram_wr_enable, sram_wr_addr, sram_wr_data
    );

    modport master (
        output start, start_addr, stall, cond, load_valid, load_addr, load_data, sram_rd_data,
        input  uop_valid, ctrl_out, pc, running, error, load_ready,
               sram_rd_addr, sram_wr_enable, sram_wr_addr, sram_wr_data
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches one micro-op per cycle from an external
// 1-cycle-latency SRAM, with jump/call/return through a small return stack.
// The SRAM write port is handed to the host whenever the sequencer is halted.
module microcode_sequencer #(
    parameter int DATA_WIDTH  = 46,
    parameter int SIZE        = 1024,
    parameter int ADDR_WIDTH  = $clog2(SIZE),
    parameter int STACK_DEPTH = 4,
    parameter int CTRL_WIDTH  = DATA_WIDTH - 4 - ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    microcode_sequencer_if.slave bus
);
    localparam int SPW = $clog2(STACK_DEPTH) + 1;
    localparam logic [SPW-1:0]        SP_FULL   = SPW'(STACK_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

    typedef enum logic {HALTED, RUN} state_e;
    typedef enum logic [1:0] {OP_SEQ, OP_JMP, OP_CALL, OP_RET} op_e;

    typedef struct packed {
        op_e                   op;
        logic                  cond_en;
        logic                  halt;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic [ADDR_WIDTH-1:0] target;
    } uword_t;

    state_e                state, nxt_state;
    logic [ADDR_WIDTH-1:0] pc_q, nxt_pc, pc_inc, rd_addr;
    logic [SPW-1:0]        sp, nxt_sp, sp_dec;
    logic                  err_q, nxt_err, push, taken;
    logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
    uword_t                uw;

    // The SRAM output register holds the current micro-op while running.
    assign uw     = uword_t'(bus.sram_rd_data);
    assign pc_inc = (pc_q == LAST_ADDR) ? '0 : pc_q + 1'b1;
    assign sp_dec = sp - 1'b1;
    assign taken  = (uw.op != OP_SEQ) && (!uw.cond_en || bus.cond);

    // Next-state, next-pc and stack control; the fetch address is next_pc so
    // branches cost no bubble.
    always_comb begin
        nxt_state = state;
        nxt_pc    = pc_q;
        nxt_sp    = sp;
        nxt_err   = err_q;
        push      = 1'b0;
        rd_addr   = pc_q;
        unique case (state)
            HALTED: begin
                rd_addr = bus.start_addr;
                if (bus.start) begin
                    nxt_state = RUN;
                    nxt_pc    = bus.start_addr;
                    nxt_sp    = '0;
                    nxt_err   = 1'b0;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (uw.halt) begin
                        nxt_state = HALTED;
                    end else if (!taken) begin
                        nxt_pc = pc_inc;
                    end else begin
                        unique case (uw.op)
                            OP_JMP: nxt_pc = uw.target;
                            OP_CALL: begin
                                if (sp == SP_FULL) begin
                                    nxt_err   = 1'b1;
                                    nxt_state = HALTED;
                                end else begin
                                    push   = 1'b1;
                                    nxt_sp = sp + 1'b1;
                                    nxt_pc = uw.target;
                                end
                            end
                            OP_RET: begin
                                if (sp == '0) begin
                                    nxt_err   = 1'b1;
                                    nxt_state = HALTED;
                                end else begin
                                    nxt_sp = sp_dec;
                                    nxt_pc = stack[sp_dec[SPW-2:0]];
                                end
                            end
                            default: nxt_pc = pc_inc;
                        endcase
                    end
                    rd_addr = nxt_pc;
                end
            end
            default: nxt_state = HALTED;
        endcase
    end

    // Sequencer state register; reset drops uop_valid immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HALTED;
            pc_q  <= '0;
            sp    <= '0;
            err_q <= 1'b0;
        end else begin
            state <= nxt_state;
            pc_q  <= nxt_pc;
            sp    <= nxt_sp;
            err_q <= nxt_err;
        end
    end

    // Return-stack storage; contents are only meaningful below sp.
    always_ff @(posedge clk) begin
        if (push) stack[sp[SPW-2:0]] <= pc_inc;
    end

    assign bus.uop_valid      = (state == RUN);
    assign bus.running        = (state == RUN);
    assign bus.ctrl_out       = uw.ctrl;
    assign bus.pc             = pc_q;
    assign bus.error          = err_q;
    assign bus.load_ready     = (state != RUN);
    assign bus.sram_rd_addr   = rd_addr;
    assign bus.sram_wr_enable = bus.load_valid && (state != RUN);
    assign bus.sram_wr_addr   = bus.load_addr;
    assign bus.sram_wr_data   = bus.load_data;
endmodule
